// File: rtl/reg_file_pkg.sv
// Shared constants and types for the register file with scoreboard.
// Default geometry lives here so that the top, the scoreboard and the benches agree.
package reg_file_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

endpackage : reg_file_pkg

// File: rtl/reg_scoreboard.sv
// Per-register busy bits and pending-result counter for in-order issue / out-of-order writeback.
// Busy outputs are masked when a same-cycle writeback retires the producer.
module reg_scoreboard
   import reg_file_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [ADDR_W-1:0] rs_addr_i,
   input  logic [ADDR_W-1:0] rt_addr_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic              issue_i,
   input  logic [ADDR_W-1:0] issue_addr_i,
   output logic              rs_busy_o,
   output logic              rt_busy_o,
   output logic [ADDR_W:0]   pend_cnt_o
);

   localparam int            DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

   logic [DEPTH-1:0] busy;
   logic [DEPTH-1:0] busy_next;
   logic             set_ok;
   logic             clr_ok;
   logic             clash;
   logic             inc;
   logic             dec;
   logic             rs_retire;
   logic             rt_retire;

   // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
   always_comb begin
      set_ok    = issue_i && !(ZERO_REG != 0 && issue_addr_i == '0);
      clr_ok    = we_i && !(ZERO_REG != 0 && rd_addr_i == '0);
      clash     = set_ok && clr_ok && (issue_addr_i == rd_addr_i);
      busy_next = busy;
      // Clear before set: a new producer issued on the same edge wins.
      if (clr_ok) busy_next[rd_addr_i] = 1'b0;
      if (set_ok) busy_next[issue_addr_i] = 1'b1;
      inc       = set_ok && !busy[issue_addr_i];
      dec       = clr_ok && busy[rd_addr_i] && !clash;
      rs_retire = (BYPASS != 0) && clr_ok && !clash && (rd_addr_i == rs_addr_i);
      rt_retire = (BYPASS != 0) && clr_ok && !clash && (rd_addr_i == rt_addr_i);
   end

   assign rs_busy_o = busy[rs_addr_i] && !rs_retire;
   assign rt_busy_o = busy[rt_addr_i] && !rt_retire;

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         busy       <= '0;
         pend_cnt_o <= '0;
      end else begin
         busy <= busy_next;
         if (inc && !dec)      pend_cnt_o <= pend_cnt_o + ONE;
         else if (dec && !inc) pend_cnt_o <= pend_cnt_o - ONE;
      end
   end

endmodule : reg_scoreboard

// File: rtl/reg_file_sb.sv
// Two-read / one-write register file with optional hard-wired zero register,
// optional write-to-read bypass and a result-pending scoreboard.
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [ADDR_W-1:0] rs_addr_i,
   input  logic [ADDR_W-1:0] rt_addr_i,
   output logic [DATA_W-1:0] rs_data_o,
   output logic [DATA_W-1:0] rt_data_o,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic [DATA_W-1:0] rd_data_i,
   input  logic              issue_i,
   input  logic [ADDR_W-1:0] issue_addr_i,
   output logic              rs_busy_o,
   output logic              rt_busy_o,
   output logic [ADDR_W:0]   pend_cnt_o
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic              wr_ok;
   logic              fwd_ok;

   assign wr_ok  = we_i && !(ZERO_REG != 0 && rd_addr_i == '0);
   // Reset gates forwarding so the read ports show zero while rst_n_i is low.
   assign fwd_ok = (BYPASS != 0) && wr_ok && rst_n_i;

   // NOTE: the array is reset explicitly because reset must clear every register, which rules out a RAM macro.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (wr_ok) begin
         regs[rd_addr_i] <= rd_data_i;
      end
   end

   always_comb begin
      rs_data_o = regs[rs_addr_i];
      rt_data_o = regs[rt_addr_i];
      if (fwd_ok && rd_addr_i == rs_addr_i) rs_data_o = rd_data_i;
      if (fwd_ok && rd_addr_i == rt_addr_i) rt_data_o = rd_data_i;
      if (ZERO_REG != 0 && rs_addr_i == '0) rs_data_o = '0;
      if (ZERO_REG != 0 && rt_addr_i == '0) rt_data_o = '0;
   end

   reg_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
   ) u_scoreboard (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .rs_addr_i    (rs_addr_i),
      .rt_addr_i    (rt_addr_i),
      .we_i         (we_i),
      .rd_addr_i    (rd_addr_i),
      .issue_i      (issue_i),
      .issue_addr_i (issue_addr_i),
      .rs_busy_o    (rs_busy_o),
      .rt_busy_o    (rt_busy_o),
      .pend_cnt_o   (pend_cnt_o)
   );

endmodule : reg_file_sb
